reg8_file: RTL and testbench
============================

Name: reg8_file

Overview:
- 8-entry × 8-bit register file: one synchronous write port, one asynchronous read port.
- Used as the datapath storage block in the register lab; switches drive the inputs and LEDs show the read data.
- Written data is held until the same entry is rewritten or the file is cleared.

Parameters:
- WIDTH, 8, data bits per register.
- DEPTH, 8, number of registers; must be a power of two.
- AW, $clog2(DEPTH) = 3, address width of wsel and rsel; derived, do not override.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- clr  input  1  reset, synchronous, active-low; clears every register.
- enable  input  1  write enable, active-high.
- d  input  WIDTH  write data.
- wsel  input  AW  write address.
- rsel  input  AW  read address.
- q  output  WIDTH  read data of the register selected by rsel.
- r  output  DEPTH  one-hot read-select indicator; bit rsel is 1, all others 0.

Behaviour:
- Storage: DEPTH registers mem[0..DEPTH-1], each WIDTH bits, clocked by clk.
- Reset:
  - On a rising edge with clr==0, all mem entries become 0.
  - Reset has priority over a write in the same cycle.
  - No asynchronous effect: clr is not in any sensitivity list.
- Write:
  - On a rising edge with clr==1 and enable==1, mem[wsel] <= d.
  - All other entries hold their value.
  - With enable==0, no entry changes, whatever d and wsel are.
- Read:
  - q = mem[rsel], purely combinational; changes in the same cycle rsel changes.
  - Write latency to q is one edge: q reflects new data after the writing edge, not before.
- Hold (latch function): changing d or wsel without a rising edge with enable==1 never alters q.
- Write to a register other than rsel: q is unchanged.
- r = 1 << rsel, combinational, never all-zero.
- Output values after reset: q = 0 for every rsel; r follows rsel.
- Power-up before the first reset: contents undefined; the bench must apply clr==0 for at least one edge first.
- Address range: all AW-bit addresses are valid (DEPTH is a power of two), so there is no out-of-range case.

Optional Feature:
- Macro RF_WRITE_BYPASS_EN.
- When defined: if enable==1, clr==1 and wsel==rsel, q = d combinationally in the write cycle (write-first forwarding). mem is updated at the edge as normal.
- When undefined: q always shows the stored mem[rsel]; new data appears only after the edge (read-before-write).
- Reset and r are identical in both builds.

Decomposition:
- Shared package reg8_file_pkg:
  - Constants RF_WIDTH=8, RF_DEPTH=8, RF_AW=3.
  - Typedef rf_data_t (logic [RF_WIDTH-1:0]).
  - Typedef rf_addr_t (logic [RF_AW-1:0]).
- Natural sub-module: rf_decoder, a one-hot AW-to-DEPTH decoder.
  - Instantiated twice: once for the write-enable vector gated by enable, once to produce r.
- Storage and read mux stay in reg8_file.

Test Plan:
- Reset: hold clr=0 for one edge, then clr=1; sweep rsel 0..7 -> q=8'h00 for every address; r=8'b00000001 at rsel=0 and 8'b10000000 at rsel=7.
- Fill and read: enable=1, d=8'hAA, wsel=rsel stepping 0..7, one per edge -> q=8'hAA after each writing edge; r one-hot tracks rsel.
- Read select: hold wsel=7 and d=8'hAA, step rsel 6, 5, 4 -> q=8'hAA immediately (combinational); r=8'b01000000, 8'b00100000, 8'b00010000.
- Hold, then write:
  - Preload mem[4]=8'hAA; set d=8'hBA, wsel=7, rsel=4, edge -> q stays 8'hAA.
  - Then wsel=4, edge -> q=8'hBA.
  - Then enable=0, d=8'h55, wsel=4, edge -> q stays 8'hBA.
- Reset priority: clr=0 with enable=1, d=8'hBA, wsel=7, rsel=7, edge -> q=8'h00; every other address also reads 8'h00.
- Bypass: enable=1, wsel=rsel=2, d=8'h3C, before the edge -> with RF_WRITE_BYPASS_EN q=8'h3C; without it q shows the old mem[2]. After the edge, q=8'h3C in both builds.

Source files
------------

// File: rtl/reg8_file_pkg.sv
// reg8_file_pkg: shared constants and types for the 8x8 register file.
//   RF_WIDTH  data bits per register
//   RF_DEPTH  number of registers (power of two)
//   RF_AW     address width, $clog2(RF_DEPTH)
package reg8_file_pkg;

    localparam int unsigned RF_WIDTH = 8;
    localparam int unsigned RF_DEPTH = 8;
    localparam int unsigned RF_AW    = 3;

    typedef logic [RF_WIDTH-1:0] rf_data_t;
    typedef logic [RF_AW-1:0]    rf_addr_t;

endpackage

// File: rtl/rf_decoder.sv
// rf_decoder: one-hot AW-to-DEPTH decoder with enable.
//   en_i      when low the output is all-zero
//   sel_i     binary select
//   onehot_o  bit sel_i set when en_i is high, all others clear
module rf_decoder #(
    parameter int unsigned AW    = 3,
    parameter int unsigned DEPTH = 8
) (
    input  logic             en_i,
    input  logic [AW-1:0]    sel_i,
    output logic [DEPTH-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[sel_i] = 1'b1;
        end
    end

endmodule

// File: rtl/reg8_file.sv
// reg8_file: DEPTH x WIDTH register file, one synchronous write port and one
// combinational read port.
//   clk     rising-edge clock for all state
//   clr     synchronous active-low clear of every register; wins over a write
//   enable  write enable, active-high
//   d       write data
//   wsel    write address
//   rsel    read address
//   q       mem[rsel], combinational
//   r       one-hot read-select indicator, 1 << rsel
// Build option: define RF_WRITE_BYPASS_EN to forward d onto q during a write
// cycle whose wsel equals rsel (write-first). Undefined: q shows stored data
// only, new data appearing after the writing edge.
module reg8_file
    import reg8_file_pkg::*;
#(
    parameter int unsigned WIDTH = RF_WIDTH,
    parameter int unsigned DEPTH = RF_DEPTH,  // must be a power of two
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             enable,
    input  logic [WIDTH-1:0] d,
    input  logic [AW-1:0]    wsel,
    input  logic [AW-1:0]    rsel,
    output logic [WIDTH-1:0] q,
    output logic [DEPTH-1:0] r
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] we;

    // Per-entry write strobes, already gated by enable.
    rf_decoder #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_wdec (
        .en_i     (enable),
        .sel_i    (wsel),
        .onehot_o (we)
    );

    rf_decoder #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_rdec (
        .en_i     (1'b1),
        .sel_i    (rsel),
        .onehot_o (r)
    );

    for (genvar i = 0; i < DEPTH; i++) begin : g_mem
        always_ff @(posedge clk) begin
            if (!clr) begin
                mem_q[i] <= '0;
            end else if (we[i]) begin
                mem_q[i] <= d;
            end
        end
    end

    always_comb begin
        q = mem_q[rsel];
`ifdef RF_WRITE_BYPASS_EN
        // Clear wins over forwarding: with clr low the edge stores zero, not d.
        if (enable && clr && (wsel == rsel)) begin
            q = d;
        end
`endif
    end

endmodule

// File: tb/tb_reg8_file.sv
// tb_reg8_file: directed stimulus for reg8_file with a scoreboard queue.
// Stimulus drives inputs just after each rising edge and pushes the expected
// q/r; a monitor pops and compares on every falling edge.
module tb_reg8_file;

    logic       clk = 1'b0;
    logic       clr;
    logic       enable;
    logic [7:0] d;
    logic [2:0] wsel;
    logic [2:0] rsel;
    logic [7:0] q;
    logic [7:0] r;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        string      name;
    } exp_t;

    exp_t sb[$];

`ifdef RF_WRITE_BYPASS_EN
    localparam bit Byp = 1'b1;
`else
    localparam bit Byp = 1'b0;
`endif

    reg8_file dut (
        .clk    (clk),
        .clr    (clr),
        .enable (enable),
        .d      (d),
        .wsel   (wsel),
        .rsel   (rsel),
        .q      (q),
        .r      (r)
    );

    always #5 clk = ~clk;

    // Monitor: compare everything queued for this cycle.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (q !== e.q || r !== e.r) begin
                errors++;
                $display("FAIL %s: got q=%h r=%b, expected q=%h r=%b",
                         e.name, q, r, e.q, e.r);
            end
        end
    end

    task automatic drive(input logic c, input logic en, input logic [7:0] dd,
                         input logic [2:0] ws, input logic [2:0] rs);
        @(posedge clk);
        #1;
        clr    = c;
        enable = en;
        d      = dd;
        wsel   = ws;
        rsel   = rs;
    endtask

    task automatic expect_q(input string name, input logic [7:0] eq);
        exp_t e;
        logic [7:0] one;
        one    = 8'h01;
        e.q    = eq;
        e.r    = one << rsel;
        e.name = name;
        sb.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        clr = 1'b0; enable = 1'b0; d = 8'h00; wsel = 3'd0; rsel = 3'd0;

        // Reset: clr low for one edge, then sweep every address.
        drive(1'b0, 1'b0, 8'h00, 3'd0, 3'd0);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 8'h00, 3'd0, 3'(i));
            expect_q($sformatf("reset_rd%0d", i), 8'h00);
        end

        // Fill: before the edge q is old data (or d when forwarding), after it AA.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 8'hAA, 3'(i), 3'(i));
            expect_q($sformatf("fill_pre%0d", i), Byp ? 8'hAA : 8'h00);
            drive(1'b1, 1'b0, 8'hAA, 3'(i), 3'(i));
            expect_q($sformatf("fill_post%0d", i), 8'hAA);
        end

        // Read select is combinational.
        drive(1'b1, 1'b1, 8'hAA, 3'd7, 3'd6); expect_q("rsel6", 8'hAA);
        drive(1'b1, 1'b1, 8'hAA, 3'd7, 3'd5); expect_q("rsel5", 8'hAA);
        drive(1'b1, 1'b1, 8'hAA, 3'd7, 3'd4); expect_q("rsel4", 8'hAA);

        // Hold, then write.
        drive(1'b1, 1'b1, 8'hBA, 3'd7, 3'd4); expect_q("hold_w7", 8'hAA);
        drive(1'b1, 1'b1, 8'hBA, 3'd4, 3'd4); expect_q("other_w7", Byp ? 8'hBA : 8'hAA);
        drive(1'b1, 1'b0, 8'h55, 3'd4, 3'd4); expect_q("write_w4", 8'hBA);
        drive(1'b1, 1'b0, 8'h55, 3'd4, 3'd4); expect_q("hold_en0", 8'hBA);
        drive(1'b1, 1'b0, 8'h00, 3'd0, 3'd7); expect_q("rd7_ba", 8'hBA);
        drive(1'b1, 1'b0, 8'h00, 3'd0, 3'd3); expect_q("rd3_aa", 8'hAA);

        // Reset priority over a write to the read address.
        drive(1'b0, 1'b1, 8'hBA, 3'd7, 3'd7); expect_q("rst_pre", 8'hBA);
        drive(1'b1, 1'b0, 8'h00, 3'd0, 3'd7); expect_q("rst_prio", 8'h00);
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b0, 8'h00, 3'd0, 3'(i));
            expect_q($sformatf("rst_rd%0d", i), 8'h00);
        end

        // Bypass: mem[2] first set to 11, then write 3C with wsel == rsel.
        drive(1'b1, 1'b1, 8'h11, 3'd2, 3'd0); expect_q("byp_prep", 8'h00);
        drive(1'b1, 1'b1, 8'h3C, 3'd2, 3'd2); expect_q("byp_pre", Byp ? 8'h3C : 8'h11);
        drive(1'b1, 1'b0, 8'h00, 3'd0, 3'd2); expect_q("byp_post", 8'h3C);

        // Drain the scoreboard.
        repeat (2) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
